// File: rtl/tt_sweep_checker_if.sv
// rtl/tt_sweep_checker_if.sv - sweep checker control, DUT hookup and result signals
interface tt_sweep_checker_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic                   f_in;
    logic [N_IN-1:0]        stim;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic [N_IN-1:0]        first_err_idx;
    logic                   first_err_valid;

    modport master (
        output start, expected, f_in,
        input  stim, busy, done, pass, err_count, first_err_idx, first_err_valid
    );

    modport slave (
        input  start, expected, f_in,
        output stim, busy, done, pass, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweep of a combinational DUT
module tt_sweep_checker #(
    parameter int N_IN = 4,
    parameter int HOLD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_sweep_checker_if.slave bus
);
    localparam int N_VEC = 1 << N_IN;
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   idx;
    logic [HW-1:0]     hold_cnt;
    logic [N_VEC-1:0]  exp_q;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_err_idx;
    logic              first_err_valid;
    logic              pass;
    logic              sample;
    logic              last_vec;
    logic              mismatch;
    logic [N_IN:0]     err_next;

    // Sample on the last hold cycle so the DUT output has settled on idx.
    always_comb begin
        sample   = (state == RUN) && (hold_cnt == HW'(HOLD - 1));
        last_vec = (idx == {N_IN{1'b1}});
        mismatch = sample && (bus.f_in != exp_q[idx]);
        err_next = err_count + {{N_IN{1'b0}}, mismatch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (sample && last_vec) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            hold_cnt        <= '0;
            exp_q           <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx             <= '0;
                        hold_cnt        <= '0;
                        exp_q           <= bus.expected;
                        err_count       <= '0;
                        first_err_idx   <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        hold_cnt  <= '0;
                        err_count <= err_next;
                        if (mismatch && !first_err_valid) begin
                            first_err_idx   <= idx;
                            first_err_valid <= 1'b1;
                        end
                        // pass uses err_next so the final vector's compare is included.
                        if (last_vec) begin
                            pass <= (err_next == '0);
                            idx  <= '0;
                        end else begin
                            idx <= idx + N_IN'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stim            = (state == RUN) ? idx : '0;
    assign bus.busy            = (state == RUN);
    assign bus.done            = (state == FIN);
    assign bus.pass            = pass;
    assign bus.err_count       = err_count;
    assign bus.first_err_idx   = first_err_idx;
    assign bus.first_err_valid = first_err_valid;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - randomized self-checking bench for tt_sweep_checker
module tb_tt_sweep_checker;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic [15:0] dut_tt;
    logic [15:0] parity_tt;
    int          total;
    int          bad;

    tt_sweep_checker_if #(.N_IN(4)) bus1 ();
    tt_sweep_checker_if #(.N_IN(4)) bus2 ();

    tt_sweep_checker #(.N_IN(4), .HOLD(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    tt_sweep_checker #(.N_IN(4), .HOLD(1)) u_dut_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Combinational device under test: output looked up from its own truth table.
    assign bus1.start    = start;
    assign bus1.expected = expected;
    assign bus1.f_in     = dut_tt[bus1.stim];
    assign bus2.start    = start;
    assign bus2.expected = expected;
    assign bus2.f_in     = dut_tt[bus2.stim];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [15:0] e, input logic [15:0] tt,
                             output int err, output int first, output int valid);
        err   = 0;
        first = 0;
        valid = 0;
        for (int i = 0; i < 16; i++) begin
            if (e[i] != tt[i]) begin
                err++;
                if (valid == 0) begin
                    first = i;
                    valid = 1;
                end
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_stim1"},  bus1.stim, 0);
        check({tag, "_busy1"},  bus1.busy, 0);
        check({tag, "_done1"},  bus1.done, 0);
        check({tag, "_pass1"},  bus1.pass, 0);
        check({tag, "_err1"},   bus1.err_count, 0);
        check({tag, "_fidx1"},  bus1.first_err_idx, 0);
        check({tag, "_fval1"},  bus1.first_err_valid, 0);
        check({tag, "_busy2"},  bus2.busy, 0);
        check({tag, "_pass2"},  bus2.pass, 0);
        check({tag, "_err2"},   bus2.err_count, 0);
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] exp_v,
                             input logic [15:0] tt, input int restart_at);
        int r_err, r_first, r_valid;
        ref_model(exp_v, tt, r_err, r_first, r_valid);
        dut_tt   = tt;
        expected = exp_v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            check({tag, "_busy1"}, bus1.busy, (c <= 32) ? 1 : 0);
            check({tag, "_stim1"}, bus1.stim, (c <= 32) ? (c - 1) / 2 : 0);
            check({tag, "_done1"}, bus1.done, (c == 33) ? 1 : 0);
            check({tag, "_busy2"}, bus2.busy, (c <= 16) ? 1 : 0);
            check({tag, "_stim2"}, bus2.stim, (c <= 16) ? c - 1 : 0);
            check({tag, "_done2"}, bus2.done, (c == 17) ? 1 : 0);
            if (c == 33 || c == 40) begin
                check({tag, "_err1"},  bus1.err_count, r_err);
                check({tag, "_fidx1"}, bus1.first_err_idx, r_first);
                check({tag, "_fval1"}, bus1.first_err_valid, r_valid);
                check({tag, "_pass1"}, bus1.pass, (r_err == 0) ? 1 : 0);
            end
            if (c == 17 || c == 40) begin
                check({tag, "_err2"},  bus2.err_count, r_err);
                check({tag, "_fidx2"}, bus2.first_err_idx, r_first);
                check({tag, "_fval2"}, bus2.first_err_valid, r_valid);
                check({tag, "_pass2"}, bus2.pass, (r_err == 0) ? 1 : 0);
            end
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int found;
        int done_seen;
        logic [3:0] iv;
        logic [15:0] e;
        logic [15:0] tt;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        expected = '0;
        dut_tt   = '0;
        for (int i = 0; i < 16; i++) begin
            iv           = i[3:0];
            parity_tt[i] = ^iv;
        end

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep("parity",  16'h6996, parity_tt, 0);
        run_sweep("stuck0",  16'h6996, 16'h0000, 0);
        run_sweep("bit15",   16'hE996, parity_tt, 0);
        run_sweep("restart", 16'h6996, parity_tt, 10);

        // Abort mid-sweep with an asynchronous reset while stim == 7.
        dut_tt   = parity_tt;
        expected = 16'h6996;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (bus1.stim == 4'd7) found = 1;
            else @(negedge clk);
        end
        check("abort_reached7", found, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus1.done || bus2.done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_sweep("post_abort", 16'h6996, parity_tt, 0);

        for (int k = 0; k < 6; k++) begin
            e = 16'($urandom);
            case (k % 3)
                0:       tt = e;
                1:       tt = e ^ (16'h1 << $urandom_range(0, 15));
                default: tt = 16'($urandom);
            endcase
            run_sweep($sformatf("rand%0d", k), e, tt, (k == 5) ? 5 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
